// File: rtl/spi_cfg_pkg.sv
`default_nettype none
//==============================================================================
// Module   : spi_cfg_pkg
// Purpose  : Shared definitions for the SPI configuration sequencer: one-hot
//            FSM state encoding, default timing parameters and the mismatch
//            counter width, plus a saturating increment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
package spi_cfg_pkg;

    // One-hot state encoding; bit position doubles as a state index.
    localparam logic [8:0] c_ST_IDLE      = 9'b0_0000_0001;
    localparam logic [8:0] c_ST_CHECK_LEN = 9'b0_0000_0010;
    localparam logic [8:0] c_ST_SEND      = 9'b0_0000_0100;
    localparam logic [8:0] c_ST_WAIT_BUSY = 9'b0_0000_1000;
    localparam logic [8:0] c_ST_WAIT_DONE = 9'b0_0001_0000;
    localparam logic [8:0] c_ST_READ_REQ  = 9'b0_0010_0000;
    localparam logic [8:0] c_ST_WAIT_RD   = 9'b0_0100_0000;
    localparam logic [8:0] c_ST_GAP       = 9'b0_1000_0000;
    localparam logic [8:0] c_ST_FINISH    = 9'b1_0000_0000;

    localparam int c_GAP_CYCLES_DEF     = 4;
    localparam int c_TIMEOUT_CYCLES_DEF = 1024;
    localparam int c_MISMATCH_W         = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [c_MISMATCH_W-1:0] sat_inc(input logic [c_MISMATCH_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cfg_table.sv
`default_nettype none
//==============================================================================
// Module   : spi_cfg_table
// Purpose  : DEPTH x DATA_WIDTH configuration word storage with one
//            synchronous write port and one combinational read port.
// Ports    : clk     - system clock
//            i_we    - write strobe
//            i_waddr - write address
//            i_wdata - write data
//            i_raddr - read address
//            o_rdata - read data (combinational from i_raddr)
// Revision : 1.0 - initial release
//==============================================================================
module spi_cfg_table #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    // No reset on the array: the configuration must survive a sequencer reset.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/spi_cfg_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : spi_cfg_sequencer
// Purpose  : Plays a table of sensor configuration words out to the SPI master
//            engine one word per frame, optionally reads each word back and
//            counts mismatches, with timeout protection on every handshake.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            cfg_we_i/addr/wdata - table write port (accepted in IDLE only)
//            seq_len_i, verify_i, start_i - sequence control, sampled on start
//            sdo_data_o/valid_o, sdo_ready_i - write handshake to the engine
//            sdi_ready_o, sdi_data_i/valid_i - read-back handshake
//            busy_o, done_o, timeout_o, mismatch_cnt_o, word_idx_o - status
// Revision : 1.0 - initial release
//==============================================================================
module spi_cfg_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 16,
    parameter int GAP_CYCLES     = c_GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we_i,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr_i,
    input  logic [DATA_WIDTH-1:0]    cfg_wdata_i,
    input  logic [$clog2(DEPTH):0]   seq_len_i,
    input  logic                     verify_i,
    input  logic                     start_i,
    output logic [DATA_WIDTH-1:0]    sdo_data_o,
    output logic                     sdo_valid_o,
    input  logic                     sdo_ready_i,
    output logic                     sdi_ready_o,
    input  logic [DATA_WIDTH-1:0]    sdi_data_i,
    input  logic                     sdi_valid_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic [c_MISMATCH_W-1:0]  mismatch_cnt_o,
    output logic [$clog2(DEPTH):0]   word_idx_o
);

    localparam int c_ADDR_W  = $clog2(DEPTH);
    localparam int c_IDX_W   = c_ADDR_W + 1;
    localparam int c_CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [8:0]              r_state;
    logic [8:0]              w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]      r_seq_len;
    logic                    r_verify;
    logic [c_IDX_W-1:0]      r_word_idx;
    logic [DATA_WIDTH-1:0]   r_sdo_data;
    logic                    r_timeout;
    logic [c_MISMATCH_W-1:0] r_mismatch;
    logic [DATA_WIDTH-1:0]   w_tab_rdata;
    logic                    w_tab_we;
    logic                    w_tmo_reached;
    logic                    w_tmo_fire;

    // Table is frozen while a sequence runs so the words sent are the words
    // that were loaded at start.
    assign w_tab_we = cfg_we_i && (r_state == c_ST_IDLE);

    spi_cfg_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_table (
        .clk     (clk),
        .i_we    (w_tab_we),
        .i_waddr (cfg_addr_i),
        .i_wdata (cfg_wdata_i),
        .i_raddr (r_word_idx[c_ADDR_W-1:0]),
        .o_rdata (w_tab_rdata)
    );

    // r_cnt holds the number of cycles spent in the current state, where the
    // first cycle in a state reads 1. For the wait states this makes the
    // window span TIMEOUT_CYCLES cycles measured from the cycle that issued
    // the preceding handshake step.
    assign w_tmo_reached = (r_cnt == c_TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_tmo_fire  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start_i) w_state_nxt = c_ST_CHECK_LEN;
            end
            c_ST_CHECK_LEN: begin
                w_state_nxt = (r_word_idx == r_seq_len) ? c_ST_FINISH : c_ST_SEND;
            end
            c_ST_SEND: begin
                w_state_nxt = c_ST_WAIT_BUSY;
            end
            c_ST_WAIT_BUSY: begin
                if (sdo_ready_i) begin
                    w_state_nxt = c_ST_WAIT_DONE;
                end else if (w_tmo_reached) begin
                    w_state_nxt = c_ST_FINISH;
                    w_tmo_fire  = 1'b1;
                end
            end
            c_ST_WAIT_DONE: begin
                // Falling edge of ready marks the word as fully shifted.
                if (!sdo_ready_i) begin
                    w_state_nxt = r_verify ? c_ST_READ_REQ : c_ST_GAP;
                end else if (w_tmo_reached) begin
                    w_state_nxt = c_ST_FINISH;
                    w_tmo_fire  = 1'b1;
                end
            end
            c_ST_READ_REQ: begin
                w_state_nxt = c_ST_WAIT_RD;
            end
            c_ST_WAIT_RD: begin
                if (sdi_valid_i) begin
                    w_state_nxt = c_ST_GAP;
                end else if (w_tmo_reached) begin
                    w_state_nxt = c_ST_FINISH;
                    w_tmo_fire  = 1'b1;
                end
            end
            c_ST_GAP: begin
                if (r_cnt == c_GAP_LAST) w_state_nxt = c_ST_CHECK_LEN;
            end
            c_ST_FINISH: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_seq_len  <= '0;
            r_verify   <= 1'b0;
            r_word_idx <= '0;
            r_sdo_data <= '0;
            r_timeout  <= 1'b0;
            r_mismatch <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_state_nxt != r_state) begin
                r_cnt <= c_CNT_ONE;
            end else if (r_cnt != c_CNT_SAT) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if ((r_state == c_ST_IDLE) && start_i) begin
                r_seq_len  <= seq_len_i;
                r_verify   <= verify_i;
                r_timeout  <= 1'b0;
                r_mismatch <= '0;
                r_word_idx <= '0;
            end

            // Capture on the way into SEND so the word is valid alongside
            // sdo_valid_o and stays put for the whole frame and read-back.
            if ((r_state == c_ST_CHECK_LEN) && (w_state_nxt == c_ST_SEND)) begin
                r_sdo_data <= w_tab_rdata;
            end

            if ((r_state == c_ST_WAIT_RD) && sdi_valid_i && (sdi_data_i != r_sdo_data)) begin
                r_mismatch <= sat_inc(r_mismatch);
            end

            if ((r_state == c_ST_GAP) && (w_state_nxt == c_ST_CHECK_LEN)) begin
                r_word_idx <= r_word_idx + 1'b1;
            end

            if (w_tmo_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign sdo_data_o     = r_sdo_data;
    assign sdo_valid_o    = (r_state == c_ST_SEND);
    assign sdi_ready_o    = (r_state == c_ST_READ_REQ);
    assign busy_o         = (r_state != c_ST_IDLE) && (r_state != c_ST_FINISH);
    assign done_o         = (r_state == c_ST_FINISH);
    assign timeout_o      = r_timeout;
    assign mismatch_cnt_o = r_mismatch;
    assign word_idx_o     = r_word_idx;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_spi_cfg_sequencer
// Purpose  : Self-checking bench for spi_cfg_sequencer with a behavioural SPI
//            engine (34-cycle frames, read-back loop with optional corruption,
//            stall mode) and table-driven sequence vectors.
// Ports    : none
// Revision : 1.0 - initial release
//==============================================================================
module tb_spi_cfg_sequencer;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 16;
    localparam int GAP        = 4;
    localparam int TMO        = 64;
    localparam int ENG_FRAME  = 34;
    localparam int PERIOD     = 1 + ENG_FRAME + GAP + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cfg_we_i = 1'b0;
    logic [3:0]            cfg_addr_i = '0;
    logic [DATA_WIDTH-1:0] cfg_wdata_i = '0;
    logic [4:0]            seq_len_i = '0;
    logic                  verify_i = 1'b0;
    logic                  start_i = 1'b0;
    logic [DATA_WIDTH-1:0] sdo_data_o;
    logic                  sdo_valid_o;
    logic                  sdo_ready_i = 1'b0;
    logic                  sdi_ready_o;
    logic [DATA_WIDTH-1:0] sdi_data_i = '0;
    logic                  sdi_valid_i = 1'b0;
    logic                  busy_o;
    logic                  done_o;
    logic                  timeout_o;
    logic [7:0]            mismatch_cnt_o;
    logic [4:0]            word_idx_o;

    spi_cfg_sequencer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .DEPTH          (DEPTH),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we_i       (cfg_we_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_wdata_i    (cfg_wdata_i),
        .seq_len_i      (seq_len_i),
        .verify_i       (verify_i),
        .start_i        (start_i),
        .sdo_data_o     (sdo_data_o),
        .sdo_valid_o    (sdo_valid_o),
        .sdo_ready_i    (sdo_ready_i),
        .sdi_ready_o    (sdi_ready_o),
        .sdi_data_i     (sdi_data_i),
        .sdi_valid_i    (sdi_valid_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .timeout_o      (timeout_o),
        .mismatch_cnt_o (mismatch_cnt_o),
        .word_idx_o     (word_idx_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor (sole owner of the mon_* records) ----------------
    int          mon_valid_cnt = 0;
    int          mon_sdi_cnt   = 0;
    int          mon_done_cnt  = 0;
    int          mon_done_cyc  = 0;
    logic [31:0] mon_words[$];
    int          mon_valid_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (sdo_valid_o) begin
                mon_valid_cnt = mon_valid_cnt + 1;
                mon_words.push_back(sdo_data_o);
                mon_valid_cyc.push_back(cyc);
            end
            if (sdi_ready_o) mon_sdi_cnt = mon_sdi_cnt + 1;
            if (done_o) begin
                mon_done_cnt = mon_done_cnt + 1;
                mon_done_cyc = cyc;
            end
        end
    end

    // ---------------- engine model ----------------
    bit          eng_stall    = 1'b0;
    int          eng_bad_abs  = -1;
    int          eng_word_cnt = 0;
    int          eng_idx      = 0;
    logic [31:0] eng_last     = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (sdo_valid_o && !eng_stall && !rst) begin
                eng_last     = sdo_data_o;
                eng_idx      = eng_word_cnt;
                eng_word_cnt = eng_word_cnt + 1;
                sdo_ready_i  = 1'b1;
                repeat (ENG_FRAME) @(negedge clk);
                sdo_ready_i  = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sdi_ready_o) begin
                repeat (3) @(negedge clk);
                sdi_data_i  = (eng_idx == eng_bad_abs) ? (eng_last ^ 32'h1) : eng_last;
                sdi_valid_i = 1'b1;
                @(negedge clk);
                sdi_valid_i = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] tb_tab[DEPTH];
    int b_valid = 0, b_sdi = 0, b_done = 0, start_cyc = 0;

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
        @(negedge clk);
        cfg_we_i = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] len, input bit ver, input int bad);
        @(negedge clk);
        b_valid     = mon_valid_cnt;
        b_sdi       = mon_sdi_cnt;
        b_done      = mon_done_cnt;
        eng_bad_abs = (bad >= 0) ? eng_word_cnt + bad : -1;
        seq_len_i   = len;
        verify_i    = ver;
        start_i     = 1'b1;
        start_cyc   = cyc;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (mon_done_cnt == b_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", 64'(mon_done_cnt != b_done), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [63:0] word_at(input int k);
        return (b_valid + k < mon_words.size()) ? 64'(mon_words[b_valid + k]) : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    typedef struct {
        logic [4:0] len;
        bit         ver;
        int         bad;
        int         exp_valid;
        int         exp_sdi;
        int         exp_mm;
        int         exp_idx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{len: 5'd3,  ver: 1'b0, bad: -1, exp_valid: 3,  exp_sdi: 0,  exp_mm: 0, exp_idx: 3};
        vecs[1] = '{len: 5'd3,  ver: 1'b1, bad: 1,  exp_valid: 3,  exp_sdi: 3,  exp_mm: 1, exp_idx: 3};
        vecs[2] = '{len: 5'd0,  ver: 1'b0, bad: -1, exp_valid: 0,  exp_sdi: 0,  exp_mm: 0, exp_idx: 0};
        vecs[3] = '{len: 5'd16, ver: 1'b1, bad: -1, exp_valid: 16, exp_sdi: 16, exp_mm: 0, exp_idx: 16};

        tb_tab[0] = 32'h1234_5678;
        tb_tab[1] = 32'hA5A5_A5A5;
        tb_tab[2] = 32'h0000_FFFF;
        for (int i = 3; i < DEPTH; i++) tb_tab[i] = 32'hC0DE_0000 + 32'(i);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs",
              {14'd0, sdo_data_o, sdo_valid_o, sdi_ready_o, busy_o, done_o, timeout_o, mismatch_cnt_o, word_idx_o},
              64'd0);

        for (int i = 0; i < DEPTH; i++) cfg_write(4'(i), tb_tab[i]);

        // ---------------- table-driven sequences ----------------
        for (int v = 0; v < 4; v++) begin
            do_start(vecs[v].len, vecs[v].ver, vecs[v].bad);
            wait_done(2000);
            check($sformatf("v%0d_valid_cnt", v), 64'(mon_valid_cnt - b_valid), 64'(vecs[v].exp_valid));
            check($sformatf("v%0d_sdi_cnt", v), 64'(mon_sdi_cnt - b_sdi), 64'(vecs[v].exp_sdi));
            check($sformatf("v%0d_done_cnt", v), 64'(mon_done_cnt - b_done), 64'd1);
            check($sformatf("v%0d_mismatch", v), 64'(mismatch_cnt_o), 64'(vecs[v].exp_mm));
            check($sformatf("v%0d_timeout", v), 64'(timeout_o), 64'd0);
            check($sformatf("v%0d_word_idx", v), 64'(word_idx_o), 64'(vecs[v].exp_idx));
            check($sformatf("v%0d_busy_after", v), 64'(busy_o), 64'd0);
            for (int k = 0; k < vecs[v].exp_valid; k++)
                check($sformatf("v%0d_word%0d", v, k), word_at(k), 64'(tb_tab[k % DEPTH]));
            if (vecs[v].exp_valid > 0)
                check($sformatf("v%0d_start_to_valid", v),
                      (mon_valid_cyc.size() > b_valid) ? 64'(mon_valid_cyc[b_valid] - start_cyc) : 64'hFFFF,
                      64'd2);
            else
                check($sformatf("v%0d_start_to_done", v), 64'(mon_done_cyc - start_cyc), 64'd2);
            if (!vecs[v].ver) begin
                for (int k = 1; k < vecs[v].exp_valid; k++)
                    check($sformatf("v%0d_period%0d", v, k),
                          (mon_valid_cyc.size() > b_valid + k)
                              ? 64'(mon_valid_cyc[b_valid + k] - mon_valid_cyc[b_valid + k - 1]) : 64'hFFFF,
                          64'(PERIOD));
            end
        end

        // ---------------- write attempt while busy ----------------
        begin
            int n = 0;
            do_start(5'd3, 1'b0, -1);
            while (mon_valid_cnt == b_valid && n < 50) begin @(negedge clk); n++; end
            cfg_write(4'd1, 32'hDEAD_BEEF);
            wait_done(1000);
            check("busy_write_word1", word_at(1), 64'(tb_tab[1]));
            do_start(5'd3, 1'b0, -1);
            wait_done(1000);
            check("busy_write_replay_cnt", 64'(mon_valid_cnt - b_valid), 64'd3);
            check("busy_write_replay_word1", word_at(1), 64'(tb_tab[1]));
        end

        // ---------------- reset during WAIT_DONE of word 1 ----------------
        begin
            int n = 0;
            do_start(5'd3, 1'b0, -1);
            while ((mon_valid_cnt - b_valid) < 2 && n < 200) begin @(negedge clk); n++; end
            repeat (5) @(negedge clk);
            check("pre_rst_busy", 64'(busy_o), 64'd1);
            check("pre_rst_word_idx", 64'(word_idx_o), 64'd1);
            rst = 1'b1;
            @(negedge clk);
            check("mid_rst_outputs",
                  {14'd0, sdo_data_o, sdo_valid_o, sdi_ready_o, busy_o, done_o, timeout_o, mismatch_cnt_o, word_idx_o},
                  64'd0);
            rst = 1'b0;
            n = 0;
            while (sdo_ready_i && n < 100) begin @(negedge clk); n++; end
            do_start(5'd3, 1'b0, -1);
            wait_done(1000);
            check("post_rst_valid_cnt", 64'(mon_valid_cnt - b_valid), 64'd3);
            for (int k = 0; k < 3; k++)
                check($sformatf("post_rst_word%0d", k), word_at(k), 64'(tb_tab[k]));
            check("post_rst_word_idx", 64'(word_idx_o), 64'd3);
        end

        // ---------------- stalled engine -> timeout ----------------
        eng_stall = 1'b1;
        do_start(5'd3, 1'b0, -1);
        wait_done(300);
        check("tmo_done_latency", 64'(mon_done_cyc - start_cyc), 64'(TMO + 2));
        check("tmo_flag", 64'(timeout_o), 64'd1);
        check("tmo_word_idx", 64'(word_idx_o), 64'd0);
        check("tmo_valid_cnt", 64'(mon_valid_cnt - b_valid), 64'd1);
        check("tmo_done_cnt", 64'(mon_done_cnt - b_done), 64'd1);
        check("tmo_busy_after", 64'(busy_o), 64'd0);
        eng_stall = 1'b0;

        // Sticky timeout clears on the next start.
        do_start(5'd0, 1'b0, -1);
        wait_done(20);
        check("tmo_cleared_on_start", 64'(timeout_o), 64'd0);
        check("tmo_clear_seq_valid_cnt", 64'(mon_valid_cnt - b_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
